// File: rtl/temporizador_param_if.sv
// Phase-generator bus: decoder-side controls in, one-hot phase and completion status out.
interface temporizador_param_if #(
    parameter int unsigned NPHASES = 8,
    parameter int unsigned IDX_W   = $clog2(NPHASES),
    parameter int unsigned CNT_W   = 16
);
    logic               go_t0;
    logic               hold;
    logic [IDX_W-1:0]   last_phase;
    logic               jump_valid;
    logic [IDX_W-1:0]   jump_phase;
    logic [NPHASES-1:0] t;
    logic [IDX_W-1:0]   phase_idx;
    logic               instr_done;
    logic [CNT_W-1:0]   instr_count;

    modport master (
        output go_t0, hold, last_phase, jump_valid, jump_phase,
        input  t, phase_idx, instr_done, instr_count
    );

    modport slave (
        input  go_t0, hold, last_phase, jump_valid, jump_phase,
        output t, phase_idx, instr_done, instr_count
    );
endinterface

// File: rtl/temporizador_param.sv
// Parametrised control-unit timing generator: one-hot phases with programmable
// last phase, stall, jump, abort-to-T0 and a completed-instruction counter.
module temporizador_param #(
    parameter int unsigned NPHASES = 8,
    parameter int unsigned IDX_W   = $clog2(NPHASES),
    parameter int unsigned CNT_W   = 16
) (
    input  logic                 ck,
    input  logic                 reset,
    temporizador_param_if.slave  bus
);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NPHASES - 1);

    logic [IDX_W-1:0]   phase_q, phase_d;
    logic [NPHASES-1:0] t_q, t_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   last_eff;
    logic [IDX_W-1:0]   jump_eff;

    // Clamp indices so a non-power-of-two phase count never leaves the legal range.
    always_comb begin
        last_eff = (bus.last_phase > MAX_IDX) ? MAX_IDX : bus.last_phase;
        jump_eff = (bus.jump_phase > MAX_IDX) ? MAX_IDX : bus.jump_phase;
    end

    always_comb begin
        phase_d = phase_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        if (bus.go_t0) begin
            phase_d = '0;
        end else if (!bus.hold) begin
            if (bus.jump_valid) begin
                phase_d = jump_eff;
            end else if (phase_q >= last_eff) begin
                // >= so a last phase lowered mid-instruction still wraps immediately
                phase_d = '0;
                done_d  = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
            end else begin
                phase_d = phase_q + IDX_W'(1);
            end
        end
        t_d = NPHASES'(1) << phase_d;
    end

    always_ff @(posedge ck) begin
        if (reset) begin
            phase_q <= '0;
            t_q     <= NPHASES'(1);
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            t_q     <= t_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.t           = t_q;
    assign bus.phase_idx   = phase_q;
    assign bus.instr_done  = done_q;
    assign bus.instr_count = cnt_q;
endmodule
